// File: rtl/cic_decim_ctrl.sv
// Decimation controller for an order-3 CIC filter: gates the integrator and comb
// clock enables, discards the first output strobes after start or reconfiguration.
module cic_decim_ctrl #(
  parameter  int RMAX  = 64,
  parameter  int RDEF  = 64,
  parameter  int FLUSH = 3,
  localparam int RW    = $clog2(RMAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          in_valid,
  input  logic [RW-1:0] ratio,
  input  logic          ratio_load,
  output logic          en_in,
  output logic          en_out,
  output logic          out_valid,
  output logic [RW-1:0] phase,
  output logic          cfg_err
);

  localparam int FW = $clog2(FLUSH + 2);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN} state_t;

  // With no strobes to discard, start-up goes straight to RUN.
  localparam state_t ENTRY = (FLUSH == 0) ? S_RUN : S_FLUSH;

  state_t        state;
  logic [RW-1:0] ratio_q;
  logic [FW-1:0] fcnt;
  logic          load_legal;
  logic          load_ok;
  logic          load_bad;
  logic          active;
  logic          frame_end;
  logic          flush_done;

  assign load_legal = (ratio >= RW'(2)) && (ratio <= RW'(RMAX));
  assign load_ok    = ratio_load && load_legal;
  assign load_bad   = ratio_load && !load_legal;
  assign active     = run && (state != S_IDLE);

  // A sample arriving with an accepted reconfiguration is dropped, not counted.
  assign en_in      = in_valid && active && !load_ok;
  assign frame_end  = en_in && (phase == ratio_q - RW'(1));
  assign flush_done = (state == S_FLUSH) && en_out && (fcnt == FW'(FLUSH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ratio_q   <= RW'(RDEF);
      phase     <= '0;
      fcnt      <= '0;
      en_out    <= 1'b0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (load_ok) ratio_q <= ratio;
      if (load_bad) cfg_err <= 1'b1;

      if (!run) begin
        state     <= S_IDLE;
        phase     <= '0;
        fcnt      <= '0;
        en_out    <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        // Only comb strobes taken after the flush window carry settled samples.
        out_valid <= en_out && (state == S_RUN);
        case (state)
          S_IDLE: begin
            state  <= ENTRY;
            phase  <= '0;
            fcnt   <= '0;
            en_out <= 1'b0;
          end
          default: begin
            if (load_ok) begin
              state  <= ENTRY;
              phase  <= '0;
              fcnt   <= '0;
              en_out <= 1'b0;
            end else begin
              en_out <= frame_end;
              if (en_in) phase <= frame_end ? '0 : phase + RW'(1);
              if ((state == S_FLUSH) && en_out) begin
                fcnt <= fcnt + FW'(1);
                if (flush_done) state <= S_RUN;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl at default parameters (RMAX=64, RDEF=64, FLUSH=3).
module tb_cic_decim_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       in_valid;
  logic [6:0] ratio;
  logic       ratio_load;
  logic       en_in;
  logic       en_out;
  logic       out_valid;
  logic [6:0] phase;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  cic_decim_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .in_valid   (in_valid),
    .ratio      (ratio),
    .ratio_load (ratio_load),
    .en_in      (en_in),
    .en_out     (en_out),
    .out_valid  (out_valid),
    .phase      (phase),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; in_valid = 1'b1; ratio = 7'd0; ratio_load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_en_out", int'(en_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_en_in", int'(en_in), 0);

    // Ratio 4 loaded while idle, then continuous input.
    reset = 1'b0; run = 1'b0; in_valid = 1'b0; ratio = 7'd4; ratio_load = 1'b1;
    tick();
    ratio_load = 1'b0; run = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick(); #1;
      chk("s1_en_in", int'(en_in), 1);
      chk("s1_phase", int'(phase), (k - 1) % 4);
      chk("s1_en_out", int'(en_out), int'(k >= 5 && (k - 5) % 4 == 0));
      chk("s1_out_valid", int'(out_valid), int'(k >= 18 && (k - 18) % 4 == 0));
    end

    // Restart with a sample every third cycle.
    run = 1'b0; in_valid = 1'b0;
    tick();
    run = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      in_valid = (c % 3 == 1);
      #1;
      chk("s2_en_in", int'(en_in), int'(c % 3 == 1));
      chk("s2_en_out", int'(en_out), int'(c == 11 || c == 23 || c == 35));
      chk("s2_out_valid", int'(out_valid), 0);
      if (c % 3 == 1) chk("s2_phase", int'(phase), ((c - 1) / 3) % 4);
    end

    // Reconfigure to ratio 8 while a sample arrives mid-frame.
    tick(); in_valid = 1'b1; #1;
    chk("s3_pre_phase0", int'(phase), 0);
    tick(); ratio = 7'd8; ratio_load = 1'b1; #1;
    chk("s3_pre_phase1", int'(phase), 1);
    chk("s3_load_en_in", int'(en_in), 0);

    for (int d = 1; d <= 109; d++) begin
      tick();
      ratio_load = (d == 44 || d == 46);
      ratio      = (d == 44) ? 7'd1 : ((d == 46) ? 7'd65 : 7'd8);
      run        = (d < 65 || d >= 67);
      in_valid   = 1'b1;
      #1;
      if (d == 1) chk("s3_phase_clr", int'(phase), 0);
      if (d < 65) begin
        chk("s34_en_in", int'(en_in), 1);
        chk("s34_en_out", int'(en_out), int'(d >= 9 && (d - 9) % 8 == 0));
        chk("s34_out_valid", int'(out_valid), int'(d >= 34 && (d - 34) % 8 == 0));
        chk("s4_cfg_err", int'(cfg_err), int'(d >= 45));
      end else if (d == 65) begin
        chk("s5_drop_en_in", int'(en_in), 0);
      end else if (d == 66) begin
        chk("s5_drop_out_valid", int'(out_valid), 0);
        chk("s5_drop_en_out", int'(en_out), 0);
        chk("s5_drop_phase", int'(phase), 0);
      end else if (d == 67) begin
        chk("s5_idle_en_in", int'(en_in), 0);
        chk("s5_idle_en_out", int'(en_out), 0);
      end else begin
        chk("s5_phase", int'(phase), (d - 68) % 8);
        chk("s5_en_out", int'(en_out), int'(d >= 76 && (d - 76) % 8 == 0));
        chk("s5_out_valid", int'(out_valid), int'(d == 101 || d == 109));
        chk("s5_cfg_err", int'(cfg_err), 1);
      end
    end

    // Asynchronous reset between edges, mid-frame.
    #1 reset = 1'b1;
    #1;
    chk("s6_out_valid", int'(out_valid), 0);
    chk("s6_en_out", int'(en_out), 0);
    chk("s6_phase", int'(phase), 0);
    chk("s6_cfg_err", int'(cfg_err), 0);
    chk("s6_en_in", int'(en_in), 0);
    #1 reset = 1'b0;
    for (int e = 1; e <= 65; e++) begin
      tick(); #1;
      chk("s6_rdef_en_out", int'(en_out), int'(e == 65));
      if (e == 33) chk("s6_rdef_phase", int'(phase), 32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
